// File: rtl/lc3b_line_responder.sv
// lc3b_line_responder: turns 128-bit line reads/writes from an LC-3b cache
// into eight 16-bit word beats on a simple req/ack word-memory port.
// Each beat is held until mem_ack. The ack of the eighth beat ends the
// transfer, and a one-cycle pmem_resp pulse follows.
// Optional feature macro: LINE_RESP_CRITICAL_WORD_FIRST_EN. When it is
// defined, a read starts at beat pmem_address[3:1] and wraps around.
// Writes always start at beat 0.
module lc3b_line_responder #(
  parameter int ADDR_W     = 16,
  parameter int LINE_WORDS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pmem_read,
  input  logic              pmem_write,
  input  logic [ADDR_W-1:0] pmem_address,
  input  logic [127:0]      pmem_wdata,
  output logic              pmem_resp,
  output logic [127:0]      pmem_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  // done_r value at which the current ack completes the line
  localparam logic [3:0] LAST_DONE = 4'(LINE_WORDS - 1);

  state_t              state_r;
  logic [ADDR_W-5:0]   line_r;
  logic [127:0]        wline_r;
  logic [2:0]          beat_r;
  logic [3:0]          done_r;

  logic [2:0]          start_beat_s;
  logic [2:0]          next_beat_s;
  logic [6:0]          word_base_s;
  logic                unused_s;

  // Extract 16-bit word idx from a 128-bit line
  function automatic logic [15:0] word_of(input logic [127:0] line,
                                          input logic [2:0]   idx);
    logic [6:0] base;
    base    = {idx, 4'b0000};
    word_of = line[base +: 16];
  endfunction

  // Starting read beat, next beat (3-bit wrap) and the rdata word offset
  always_comb begin
    start_beat_s = 3'd0;
`ifdef LINE_RESP_CRITICAL_WORD_FIRST_EN
    if (pmem_write) begin
      start_beat_s = 3'd0;
    end else begin
      start_beat_s = pmem_address[3:1];
    end
`else
    start_beat_s = 3'd0;
`endif
    next_beat_s = beat_r + 3'd1;
    word_base_s = {beat_r, 4'b0000};
  end

  // Byte-within-word bit and, in some builds, the whole low nibble are unused
  assign unused_s = ^pmem_address[3:0];

  // Transfer FSM with registered word-port and line-port outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      line_r     <= '0;
      wline_r    <= 128'd0;
      beat_r     <= 3'd0;
      done_r     <= 4'd0;
      pmem_resp  <= 1'b0;
      pmem_rdata <= 128'd0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 16'd0;
    end else begin
      case (state_r)
        IDLE: begin
          pmem_resp <= 1'b0;
          if (pmem_write) begin
            state_r   <= WRITE;
            line_r    <= pmem_address[ADDR_W-1:4];
            wline_r   <= pmem_wdata;
            beat_r    <= 3'd0;
            done_r    <= 4'd0;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= {pmem_address[ADDR_W-1:4], 3'd0, 1'b0};
            mem_wdata <= word_of(pmem_wdata, 3'd0);
          end else if (pmem_read) begin
            state_r   <= READ;
            line_r    <= pmem_address[ADDR_W-1:4];
            wline_r   <= pmem_wdata;
            beat_r    <= start_beat_s;
            done_r    <= 4'd0;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= {pmem_address[ADDR_W-1:4], start_beat_s, 1'b0};
            mem_wdata <= 16'd0;
          end else begin
            state_r <= IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
          end
        end
        READ: begin
          if (mem_ack) begin
            pmem_rdata[word_base_s +: 16] <= mem_rdata;
            beat_r   <= next_beat_s;
            done_r   <= done_r + 4'd1;
            mem_addr <= {line_r, next_beat_s, 1'b0};
            if (done_r == LAST_DONE) begin
              state_r   <= RESP;
              mem_req   <= 1'b0;
              mem_we    <= 1'b0;
              pmem_resp <= 1'b1;
            end else begin
              state_r <= READ;
            end
          end else begin
            state_r <= READ;
          end
        end
        WRITE: begin
          if (mem_ack) begin
            beat_r    <= next_beat_s;
            done_r    <= done_r + 4'd1;
            mem_addr  <= {line_r, next_beat_s, 1'b0};
            mem_wdata <= word_of(wline_r, next_beat_s);
            if (done_r == LAST_DONE) begin
              state_r   <= RESP;
              mem_req   <= 1'b0;
              mem_we    <= 1'b0;
              pmem_resp <= 1'b1;
            end else begin
              state_r <= WRITE;
            end
          end else begin
            state_r <= WRITE;
          end
        end
        RESP: begin
          // Requests still held here are deliberately not sampled
          pmem_resp <= 1'b0;
          state_r   <= IDLE;
        end
        default: begin
          state_r   <= IDLE;
          pmem_resp <= 1'b0;
          mem_req   <= 1'b0;
          mem_we    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lc3b_line_responder.sv
// Directed self-checking bench for lc3b_line_responder.
// Outputs are sampled on the falling clock edge, and inputs are driven there.
module tb_lc3b_line_responder;

  logic         clk;
  logic         rst_n;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic         pmem_resp;
  logic [127:0] pmem_rdata;
  logic         mem_req;
  logic         mem_we;
  logic [15:0]  mem_addr;
  logic [15:0]  mem_wdata;
  logic         mem_ack;
  logic [15:0]  mem_rdata;

  int checks;
  int errors;
  logic [15:0] addr_log [8];

  lc3b_line_responder #(.ADDR_W(16), .LINE_WORDS(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_resp    (pmem_resp),
    .pmem_rdata   (pmem_rdata),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read driver with an always-acking word memory whose word i holds base+i.
  // It records the beat addresses and the cycle in which pmem_resp appears.
  // The request cycle counts as cycle 1.
  task automatic run_read(input logic [15:0] addr, input logic [15:0] base,
                          input bit hold, output int resp_cyc,
                          output int nbeats, output int we_count);
    @(negedge clk);
    pmem_address = addr;
    pmem_read    = 1'b1;
    mem_ack      = 1'b1;
    resp_cyc = 0; nbeats = 0; we_count = 0;
    for (int cyc = 1; cyc <= 30 && resp_cyc == 0; cyc++) begin
      @(negedge clk);
      if (pmem_resp) begin
        resp_cyc = cyc + 1;
        if (!hold) pmem_read = 1'b0;
      end
      if (mem_req) begin
        if (nbeats < 8) addr_log[nbeats] = mem_addr;
        if (mem_we) we_count++;
        mem_rdata = base + 16'(mem_addr[3:1]);
        nbeats++;
      end
    end
    mem_ack = 1'b0;
    if (!hold) pmem_read = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (pmem_resp !== 1'b0 || mem_req !== 1'b0 || mem_we !== 1'b0 ||
        mem_addr !== 16'h0000 || mem_wdata !== 16'h0000 || pmem_rdata !== 128'd0) begin
      errors++;
      $display("FAIL reset_during: resp=%b req=%b we=%b addr=%h wdata=%h rdata=%h, required all zero",
               pmem_resp, mem_req, mem_we, mem_addr, mem_wdata, pmem_rdata);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0 || pmem_resp !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: req=%b resp=%b, required 0 0", mem_req, pmem_resp);
    end
  endtask

  task automatic test_read();
    int rc, nb, wc;
    logic [15:0] ea;
    run_read(16'h1230, 16'h1000, 1'b0, rc, nb, wc);
    checks++;
    if (rc !== 10) begin errors++; $display("FAIL read_latency: got cycle %0d, required 10", rc); end
    checks++;
    if (nb !== 8 || wc !== 0) begin
      errors++; $display("FAIL read_beats: beats=%0d we_beats=%0d, required 8 0", nb, wc);
    end
    for (int i = 0; i < 8; i++) begin
      ea = 16'h1230 + 16'(2 * i);
      checks++;
      if (addr_log[i] !== ea) begin
        errors++; $display("FAIL read_addr%0d: got %h, required %h", i, addr_log[i], ea);
      end
    end
    @(negedge clk);
    checks++;
    if (pmem_resp !== 1'b0 || pmem_rdata !== 128'h1007_1006_1005_1004_1003_1002_1001_1000) begin
      errors++;
      $display("FAIL read_line: resp=%b rdata=%h, required 0 %h", pmem_resp, pmem_rdata,
               128'h1007_1006_1005_1004_1003_1002_1001_1000);
    end
  endtask

  task automatic test_write();
    int beats, waitc, resps;
    logic [15:0] ea, ed;
    @(negedge clk);
    pmem_address = 16'h0040;
    pmem_wdata   = 128'hFFFF_EEEE_DDDD_CCCC_BBBB_AAAA_9999_8888;
    pmem_write   = 1'b1;
    mem_ack      = 1'b0;
    beats = 0; waitc = 0; resps = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (pmem_resp) begin resps++; pmem_write = 1'b0; end
      if (mem_req) begin
        ea = 16'h0040 + 16'(2 * beats);
        ed = 16'h8888 + 16'(32'h1111 * beats);
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== ea || mem_wdata !== ed) begin
          errors++;
          $display("FAIL write_beat%0d: we=%b addr=%h data=%h, required we=1 addr=%h data=%h",
                   beats, mem_we, mem_addr, mem_wdata, ea, ed);
        end
        if (waitc == 2) begin mem_ack = 1'b1; waitc = 0; beats++; end
        else begin mem_ack = 1'b0; waitc++; end
      end else begin
        mem_ack = 1'b0;
      end
    end
    mem_ack = 1'b0; pmem_write = 1'b0;
    checks++;
    if (resps !== 1 || beats !== 8) begin
      errors++; $display("FAIL write_done: resp pulses=%0d beats=%0d, required 1 8", resps, beats);
    end
  endtask

  task automatic test_simultaneous();
    int beats, resps;
    logic [15:0] ea, ed;
    @(negedge clk);
    pmem_address = 16'h0080;
    pmem_wdata   = 128'h7777_6666_5555_4444_3333_2222_1111_0000;
    pmem_write   = 1'b1;
    pmem_read    = 1'b1;
    mem_ack      = 1'b1;
    beats = 0; resps = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (pmem_resp) begin resps++; pmem_write = 1'b0; pmem_read = 1'b0; end
      if (mem_req) begin
        ea = 16'h0080 + 16'(2 * beats);
        ed = 16'(32'h1111 * beats);
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== ea || mem_wdata !== ed) begin
          errors++;
          $display("FAIL both_beat%0d: we=%b addr=%h data=%h, required we=1 addr=%h data=%h",
                   beats, mem_we, mem_addr, mem_wdata, ea, ed);
        end
        beats++;
      end
    end
    mem_ack = 1'b0; pmem_write = 1'b0; pmem_read = 1'b0;
    checks++;
    if (resps !== 1 || beats !== 8) begin
      errors++; $display("FAIL both_done: resp pulses=%0d beats=%0d, required 1 8", resps, beats);
    end
    checks++;
    if (pmem_rdata !== 128'h1007_1006_1005_1004_1003_1002_1001_1000) begin
      errors++; $display("FAIL both_rdata_hold: got %h, required previous read line", pmem_rdata);
    end
  endtask

  task automatic test_critical_word();
    int rc, nb, wc;
    logic [15:0] ea;
    logic [127:0] exp_line;
    for (int i = 0; i < 8; i++) exp_line[16*i +: 16] = 16'h2000 + 16'(i);
    run_read(16'h200A, 16'h2000, 1'b0, rc, nb, wc);
    checks++;
    if (rc !== 10 || nb !== 8) begin
      errors++; $display("FAIL cwf_latency: cycle=%0d beats=%0d, required 10 8", rc, nb);
    end
    for (int i = 0; i < 8; i++) begin
`ifdef LINE_RESP_CRITICAL_WORD_FIRST_EN
      ea = 16'h2000 + 16'(2 * ((5 + i) % 8));
`else
      ea = 16'h2000 + 16'(2 * i);
`endif
      checks++;
      if (addr_log[i] !== ea) begin
        errors++; $display("FAIL cwf_addr%0d: got %h, required %h", i, addr_log[i], ea);
      end
    end
    @(negedge clk);
    checks++;
    if (pmem_rdata !== exp_line) begin
      errors++; $display("FAIL cwf_line: got %h, required %h", pmem_rdata, exp_line);
    end
  endtask

  task automatic test_reset_mid();
    int beats, rc, nb, wc, stray;
    bit stop;
    logic [127:0] exp_line;
    for (int i = 0; i < 8; i++) exp_line[16*i +: 16] = 16'h3000 + 16'(i);
    @(negedge clk);
    pmem_address = 16'h3000; pmem_read = 1'b1; mem_ack = 1'b1;
    beats = 0; stop = 1'b0;
    for (int cyc = 0; cyc < 20 && !stop; cyc++) begin
      @(negedge clk);
      if (mem_req) begin
        if (beats == 4) stop = 1'b1;
        else begin mem_rdata = 16'h3000 + 16'(mem_addr[3:1]); beats++; end
      end
    end
    rst_n = 1'b0; pmem_read = 1'b0; mem_ack = 1'b0;
    #1;
    checks++;
    if (beats !== 4 || pmem_resp !== 1'b0 || mem_req !== 1'b0 || mem_we !== 1'b0 ||
        mem_addr !== 16'h0000 || mem_wdata !== 16'h0000 || pmem_rdata !== 128'd0) begin
      errors++;
      $display("FAIL rst_mid_zero: beats=%0d resp=%b req=%b we=%b addr=%h wdata=%h rdata=%h, required 4 and all zero",
               beats, pmem_resp, mem_req, mem_we, mem_addr, mem_wdata, pmem_rdata);
    end
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    stray = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      if (pmem_resp || mem_req) stray++;
    end
    checks++;
    if (stray !== 0) begin
      errors++; $display("FAIL rst_mid_quiet: %0d cycles with resp/req, required 0", stray);
    end
    run_read(16'h3000, 16'h3000, 1'b0, rc, nb, wc);
    checks++;
    if (rc !== 10 || nb !== 8 || addr_log[0] !== 16'h3000) begin
      errors++;
      $display("FAIL rst_mid_restart: cycle=%0d beats=%0d first=%h, required 10 8 3000", rc, nb, addr_log[0]);
    end
    @(negedge clk);
    checks++;
    if (pmem_rdata !== exp_line) begin
      errors++; $display("FAIL rst_mid_line: got %h, required %h", pmem_rdata, exp_line);
    end
  endtask

  task automatic test_held_resp();
    int rc, nb, wc;
    logic [127:0] exp_line;
    for (int i = 0; i < 8; i++) exp_line[16*i +: 16] = 16'h4000 + 16'(i);
    run_read(16'h4000, 16'h4000, 1'b1, rc, nb, wc);
    checks++;
    if (rc !== 10 || nb !== 8) begin
      errors++; $display("FAIL held_xfer: cycle=%0d beats=%0d, required 10 8", rc, nb);
    end
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0 || pmem_resp !== 1'b0) begin
      errors++; $display("FAIL held_no_restart: req=%b resp=%b, required 0 0", mem_req, pmem_resp);
    end
    pmem_read = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 16'hDEAD;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b0 || pmem_resp !== 1'b0 || pmem_rdata !== exp_line) begin
        errors++;
        $display("FAIL stray_ack%0d: req=%b resp=%b rdata=%h, required 0 0 %h",
                 cyc, mem_req, pmem_resp, pmem_rdata, exp_line);
      end
    end
    mem_ack = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; pmem_read = 1'b0; pmem_write = 1'b0;
    pmem_address = 16'h0000; pmem_wdata = 128'd0;
    mem_ack = 1'b0; mem_rdata = 16'h0000;
    for (int i = 0; i < 8; i++) addr_log[i] = 16'h0000;
    @(negedge clk);
    test_reset();
    test_read();
    test_write();
    test_simultaneous();
    test_critical_word();
    test_reset_mid();
    test_held_resp();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
